// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter.
// Used by the register file and the pipeline stages.
package regfile_wb_arbiter_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 1 << ADDR_W;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_idx_e;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [NREGS-1:0]  busy_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback, issue and register-file port bundle.
// Master is the pipeline side, slave is the arbiter.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic  req0_valid;
    addr_t req0_addr;
    data_t req0_data;
    logic  req0_ready;

    logic  req1_valid;
    addr_t req1_addr;
    data_t req1_data;
    logic  req1_ready;

    logic  issue_valid;
    addr_t issue_addr;
    logic  issue_ready;

    logic  rf_we;
    addr_t rf_waddr;
    data_t rf_wdata;
    busy_t busy;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        output issue_valid, issue_addr,
        input  issue_ready,
        input  rf_we, rf_waddr, rf_wdata, busy
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        input  issue_valid, issue_addr,
        output issue_ready,
        output rf_we, rf_waddr, rf_wdata, busy
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// Last grant flop moves only when a grant is taken.
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    req_idx_e last_grant;

    // grant from valids; on contention favour the one not granted last
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == REQ_ALU) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // remember the winner of each accepted transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= REQ_LSU;
        end else if (|grant) begin
            last_grant <= grant[1] ? REQ_LSU : REQ_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load unit
// and keeps the per-register busy scoreboard for issue.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    logic [1:0] grant;
    logic       xfer;
    addr_t      sel_addr;
    data_t      sel_data;
    logic       issue_acc;
    busy_t      busy_q;
    busy_t      busy_n;
    logic       we_q;
    addr_t      waddr_q;
    data_t      wdata_q;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({bus.req1_valid, bus.req0_valid}),
        .grant (grant)
    );

    assign bus.req0_ready  = grant[0];
    assign bus.req1_ready  = grant[1];
    assign xfer            = |grant;
    assign sel_addr        = grant[1] ? bus.req1_addr : bus.req0_addr;
    assign sel_data        = grant[1] ? bus.req1_data : bus.req0_data;

    assign bus.issue_ready = ~busy_q[bus.issue_addr];
    assign issue_acc       = bus.issue_valid & bus.issue_ready;

    assign bus.busy        = busy_q;
    assign bus.rf_we       = we_q;
    assign bus.rf_waddr    = waddr_q;
    assign bus.rf_wdata    = wdata_q;

    // writeback clears its destination; an issue set applied last wins
    always_comb begin
        busy_n = busy_q;
        if (xfer) begin
            busy_n[sel_addr] = 1'b0;
        end
        if (issue_acc) begin
            busy_n[bus.issue_addr] = 1'b1;
        end
    end

    // scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_n;
        end
    end

    // one-cycle write launch; address and data hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= xfer;
            if (xfer) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
// Inputs change on negedge, outputs sampled 1ns after an edge.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    data_t regs [NREGS];

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file image built from the write port
    always @(posedge clk) begin
        if (!rst && bus.rf_we) regs[bus.rf_waddr] = bus.rf_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.req0_valid  = 1'b0;
        bus.req1_valid  = 1'b0;
        bus.issue_valid = 1'b0;
    endtask

    task automatic after_pos();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < NREGS; i++) regs[i] = '0;
        rst = 1'b1;
        idle();
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
        bus.issue_addr = '0;

        after_pos();
        chk("rst_busy", 32'(bus.busy), 32'h00);
        chk("rst_we", 32'(bus.rf_we), 32'h0);
        chk("rst_waddr", 32'(bus.rf_waddr), 32'h0);
        chk("rst_wdata", 32'(bus.rf_wdata), 32'h00);
        @(negedge clk);
        rst = 1'b0;

        // build busy=0C with a write in flight, then reset mid-cycle
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_addr  = 3'd2;
        #1 chk("iss2_rdy", 32'(bus.issue_ready), 32'h1);
        @(negedge clk);
        bus.issue_addr = 3'd3;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 3'd0;
        bus.req0_data  = 8'h33;
        after_pos();
        chk("pre_busy", 32'(bus.busy), 32'h0C);
        chk("pre_we", 32'(bus.rf_we), 32'h1);
        chk("pre_wdata", 32'(bus.rf_wdata), 32'h33);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'h00);
        chk("arst_we", 32'(bus.rf_we), 32'h0);
        chk("arst_waddr", 32'(bus.rf_waddr), 32'h0);
        chk("arst_wdata", 32'(bus.rf_wdata), 32'h00);
        @(negedge clk);
        idle();
        @(negedge clk);
        rst = 1'b0;

        // contention: grants alternate starting with req0
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 3'd1;
        bus.req0_data  = 8'h11;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 3'd2;
        bus.req1_data  = 8'h22;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("cont_rdy0", 32'(bus.req0_ready), (i % 2 == 0) ? 1 : 0);
            chk("cont_rdy1", 32'(bus.req1_ready), (i % 2 == 0) ? 0 : 1);
            after_pos();
            chk("cont_we", 32'(bus.rf_we), 32'h1);
            chk("cont_waddr", 32'(bus.rf_waddr), (i % 2 == 0) ? 1 : 2);
            chk("cont_wdata", 32'(bus.rf_wdata),
                (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        @(negedge clk);
        idle();
        after_pos();
        chk("idle_we", 32'(bus.rf_we), 32'h0);
        chk("idle_waddr", 32'(bus.rf_waddr), 32'h2);
        chk("idle_wdata", 32'(bus.rf_wdata), 32'h22);
        chk("nonbusy_wb", 32'(bus.busy), 32'h00);

        // single requester
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 3'd3;
        bus.req0_data  = 8'h5A;
        #1 chk("single_rdy0", 32'(bus.req0_ready), 32'h1);
        after_pos();
        chk("single_we", 32'(bus.rf_we), 32'h1);
        chk("single_waddr", 32'(bus.rf_waddr), 32'h3);
        chk("single_wdata", 32'(bus.rf_wdata), 32'h5A);
        @(negedge clk);
        idle();
        after_pos();
        chk("single_we_off", 32'(bus.rf_we), 32'h0);

        // scoreboard set, WAW stall, clear by writeback
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_addr  = 3'd4;
        #1 chk("sb_rdy", 32'(bus.issue_ready), 32'h1);
        after_pos();
        chk("sb_set", 32'(bus.busy), 32'h10);
        @(negedge clk);
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 3'd4;
        bus.req1_data  = 8'h44;
        #1;
        chk("sb_stall", 32'(bus.issue_ready), 32'h0);
        chk("sb_rdy1", 32'(bus.req1_ready), 32'h1);
        after_pos();
        chk("sb_clr", 32'(bus.busy), 32'h00);
        chk("sb_we", 32'(bus.rf_we), 32'h1);
        chk("sb_waddr", 32'(bus.rf_waddr), 32'h4);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        #1 chk("sb_rdy_again", 32'(bus.issue_ready), 32'h1);
        bus.issue_valid = 1'b0;

        // same-edge set and clear of R5, then set R6 / clear R5
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_addr  = 3'd5;
        bus.req0_valid  = 1'b1;
        bus.req0_addr   = 3'd5;
        bus.req0_data   = 8'h55;
        after_pos();
        chk("sc_same", 32'(bus.busy), 32'h20);
        @(negedge clk);
        bus.issue_addr = 3'd6;
        bus.req0_data  = 8'h56;
        after_pos();
        chk("sc_diff", 32'(bus.busy), 32'h40);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.req0_addr   = 3'd6;
        bus.req0_data   = 8'h66;
        after_pos();
        chk("sc_clr6", 32'(bus.busy), 32'h00);

        // same-address race with last_grant=ALU: load goes first
        @(negedge clk);
        bus.req0_addr  = 3'd7;
        bus.req0_data  = 8'hAA;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 3'd7;
        bus.req1_data  = 8'hBB;
        #1;
        chk("race_rdy1", 32'(bus.req1_ready), 32'h1);
        chk("race_rdy0", 32'(bus.req0_ready), 32'h0);
        after_pos();
        chk("race_w1", 32'(bus.rf_wdata), 32'hBB);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        #1 chk("race_rdy0b", 32'(bus.req0_ready), 32'h1);
        after_pos();
        chk("race_w2", 32'(bus.rf_wdata), 32'hAA);
        @(negedge clk);
        idle();
        after_pos();
        chk("race_r7", 32'(regs[7]), 32'hAA);
        chk("rf_r1", 32'(regs[1]), 32'h11);
        chk("rf_r3", 32'(regs[3]), 32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: req0 is the ALU, req1 is the load unit.
- Tracks a per-register busy scoreboard for the decode/issue stage, so issue stalls on write-after-write hazards and reads stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file. Drives the register file's we/waddr/wdata.

Parameters:
- DATA_W, 8, width of write data.
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W (8), derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  ALU writeback request.
- req0_addr  in  ADDR_W  ALU destination register.
- req0_data  in  DATA_W  ALU result.
- req0_ready  out  1  ALU request accepted this cycle.
- req1_valid  in  1  load-unit writeback request.
- req1_addr  in  ADDR_W  load destination register.
- req1_data  in  DATA_W  load data.
- req1_ready  out  1  load request accepted this cycle.
- issue_valid  in  1  decode wants to issue an instruction that writes issue_addr.
- issue_addr  in  ADDR_W  destination of the issuing instruction.
- issue_ready  out  1  issue accepted (destination not busy).
- rf_we  out  1  register-file write enable.
- rf_waddr  out  ADDR_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- busy  out  NREGS  scoreboard; bit n = 1 while Rn has an outstanding write.

Behaviour:
- Reset (async, rst=1): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, last_grant=1 (req0 wins first contention).
- Reset mid-operation discards any in-flight write. Nothing is committed in the reset cycle.
- Grant is combinational from valids and last_grant:
  - Only one valid -> that requester is granted.
  - Both valid -> grant the requester not equal to last_grant (round-robin).
  - Neither valid -> no grant.
- reqN_ready = grant to N. Transfer = reqN_valid & reqN_ready.
- A requester holds valid/addr/data stable until it sees ready.
- At most one transfer per cycle; the loser is stalled.
- last_grant updates only on a transfer.
- Write latency is 1 cycle. On a transfer at edge k, rf_we=1 with rf_waddr/rf_wdata = the granted request for cycle k+1.
- With no transfer, rf_we=0 on the next cycle. rf_waddr/rf_wdata hold their last value.
- Same address from both requesters: serialised in grant order; the later write wins in the register file.
- issue_ready = ~busy[issue_addr]. This is combinational and reflects the registered busy value only; there is no bypass of a same-cycle clear.
- Issue accept (issue_valid & issue_ready) sets busy[issue_addr] at the next edge.
- A writeback transfer clears busy[reqN_addr] at the next edge, i.e. the same edge that launches rf_we.
- Simultaneous set and clear:
  - Same address: set wins, busy stays 1. This cannot occur through a legal issue, since issue_ready requires busy=0; the bench must still check it.
  - Different addresses: both apply.
- A writeback to a non-busy register is legal: the write is performed and busy is unchanged at 0.
- No combinational path from rf_* back to the inputs.

Decomposition:
- Shared package constants: DATA_W, ADDR_W, NREGS, and the requester index encoding (REQ_ALU=0, REQ_LSU=1). Reused by the register file and the pipeline stages.
- One natural sub-module: rr_arb2. It is a 2-way round-robin arbiter (valid[1:0] in, grant[1:0] out, last-grant flop updated on accept). The scoreboard and output registers stay in the top module.

Test Plan:
- Reset: assert rst mid-cycle with busy=8'h0C and rf_we=1 -> all outputs 0 immediately (async). After release, first contention grants req0.
- Single requester: req0_valid=1, addr=3, data=8'h5A for one cycle -> req0_ready=1 the same cycle; rf_we=1, rf_waddr=3, rf_wdata=8'h5A the next cycle; rf_we=0 after that.
- Contention: both valid continuously, req0 addr=1/data=8'h11, req1 addr=2/data=8'h22 -> grants alternate 0,1,0,1. rf writes alternate R1=0x11 and R2=0x22. Each stalled requester holds its data.
- Scoreboard: issue addr=4 -> busy=8'h10. A second issue to addr=4 -> issue_ready=0. req1 writes R4 -> busy returns to 0 on the same edge as rf_we. Issue to addr=4 is ready the following cycle.
- Simultaneous set and clear: force a same-edge issue set of R5 and writeback clear of R5 -> busy[5]=1. Issue set of R6 with writeback clear of R5 -> busy[5]=0, busy[6]=1.
- Same-address race: req0 and req1 both target R7 with data 8'hAA and 8'hBB, last_grant=0 -> req1 is written first (0xBB) and req0 second. R7 ends at 0xAA.
